icache_refill: RTL and testbench

Refill engine between the instruction cache's lowX miss port and the 32-bit instruction memory bus. It accepts one line-miss request at a time and issues sequential single-word reads from the line-aligned base address. It assembles the returned words into a BLK_SIZE-bit line and hands the line back as a single-cycle lowX response. Uncached requests fetch only the addressed word.

---
 rtl/tcore_param.sv | 51 +++++
 rtl/icache_refill.sv | 150 +++++++++++++++
 tb/tb_icache_refill.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcore_param.sv
// Shared core parameters and bus types for the instruction-side memory path.
// Contents:
//   XLEN, BLK_SIZE   - default address width and cache line width in bits
//   ilowX_req_t      - icache miss request (valid, ready, addr, uncached)
//   ilowX_res_t      - refill response (valid, line data, error)
//   imem_req_t       - 32-bit word bus read request (valid, addr)
//   imem_rsp_t       - 32-bit word bus read response (valid, data)
//   refill_state_e   - refill engine FSM states
//   align_down       - clears the low address bits below a power-of-two size
package tcore_param;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic [XLEN-1:0] addr;
        logic            uncached;
    } ilowX_req_t;

    typedef struct packed {
        logic                valid;
        logic [BLK_SIZE-1:0] data;
        logic                error;
    } ilowX_res_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } imem_rsp_t;

    typedef enum logic [1:0] {
        REFILL_IDLE = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        REFILL_DONE = 2'd3
    } refill_state_e;

    // Round an address down to a multiple of 'bytes' (a power of two).
    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr,
                                                   input int unsigned     bytes);
        return addr & ~(XLEN'(bytes) - XLEN'(1));
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Instruction cache refill engine.
// Takes one line miss at a time from the icache, reads the line word by word
// over a 32-bit memory bus starting at the line-aligned base, assembles the
// words into a line buffer and returns the line as a one-cycle response.
// Uncached misses fetch only the addressed word; the other lanes read as zero.
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   lowX_req_i       miss request (sampled only while idle)
//   lowX_res_o       line response, valid for exactly one cycle
//   mem_req_valid_o  word read request valid (registered)
//   mem_req_ready_i  memory accepts the read request
//   mem_addr_o       word read address (registered, bits [1:0] = 0)
//   mem_rsp_valid_i  read data valid (only honoured while waiting for it)
//   mem_rsp_data_i   read data
//   busy_o           high whenever a refill is in progress
module icache_refill #(
    parameter int BLK_SIZE = tcore_param::BLK_SIZE,
    parameter int XLEN     = tcore_param::XLEN
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  tcore_param::ilowX_req_t lowX_req_i,
    output tcore_param::ilowX_res_t lowX_res_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [XLEN-1:0]        mem_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [31:0]            mem_rsp_data_i,
    output logic                   busy_o
);

    localparam int W     = BLK_SIZE / 32;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    tcore_param::refill_state_e state_r, state_next_s;

    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [XLEN-1:0]        base_r, base_next_s;
    logic                   unc_r, unc_next_s;
    logic [W-1:0][31:0]     line_r, line_next_s;
    logic [CNT_W-1:0]       lane_s;
    logic                   last_s;
    logic [XLEN-1:0]        mem_addr_next_s;

    logic                   mem_req_valid_r;
    logic [XLEN-1:0]        mem_addr_r;
    logic                   res_valid_r;
    logic [BLK_SIZE-1:0]    res_data_r;
    logic                   busy_r;

    tcore_param::imem_req_t mem_req_s;
    tcore_param::imem_rsp_t mem_rsp_s;

    assign mem_rsp_s = '{valid: mem_rsp_valid_i, data: mem_rsp_data_i};
    assign mem_req_s = '{valid: mem_req_valid_r, addr: mem_addr_r};

    // Uncached words land in the lane selected by the word offset of the
    // latched address; cached words fill lanes in fetch order.
    assign lane_s = unc_r ? CNT_W'((base_r >> 2) & XLEN'(W - 1)) : cnt_r;
    assign last_s = unc_r || (cnt_r == CNT_W'(W - 1));

    // Next-state, datapath update and next read address.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        base_next_s  = base_r;
        unc_next_s   = unc_r;
        line_next_s  = line_r;
        case (state_r)
            tcore_param::REFILL_IDLE: begin
                if (lowX_req_i.valid && lowX_req_i.ready) begin
                    state_next_s = tcore_param::REFILL_REQ;
                    unc_next_s   = lowX_req_i.uncached;
                    base_next_s  = tcore_param::align_down(lowX_req_i.addr,
                                       lowX_req_i.uncached ? 32'd4 : 32'(BLK_SIZE / 8));
                    cnt_next_s   = '0;
                    line_next_s  = '0;
                end else begin
                    state_next_s = tcore_param::REFILL_IDLE;
                end
            end
            tcore_param::REFILL_REQ: begin
                if (mem_req_ready_i) begin
                    state_next_s = tcore_param::REFILL_WAIT;
                end else begin
                    state_next_s = tcore_param::REFILL_REQ;
                end
            end
            tcore_param::REFILL_WAIT: begin
                if (mem_rsp_s.valid) begin
                    line_next_s[lane_s] = mem_rsp_s.data;
                    if (last_s) begin
                        state_next_s = tcore_param::REFILL_DONE;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1);
                        state_next_s = tcore_param::REFILL_REQ;
                    end
                end else begin
                    state_next_s = tcore_param::REFILL_WAIT;
                end
            end
            tcore_param::REFILL_DONE: begin
                // No acceptance here: the earliest new miss is taken in IDLE.
                state_next_s = tcore_param::REFILL_IDLE;
            end
            default: begin
                state_next_s = tcore_param::REFILL_IDLE;
            end
        endcase
        // XLEN-bit sum wraps naturally at the top of the address space.
        mem_addr_next_s = base_next_s + (XLEN'(cnt_next_s) << 2);
    end

    // State, datapath and output registers; outputs load their next values so
    // nothing combinational reaches a port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= tcore_param::REFILL_IDLE;
            cnt_r           <= '0;
            base_r          <= '0;
            unc_r           <= 1'b0;
            line_r          <= '0;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= '0;
            res_valid_r     <= 1'b0;
            res_data_r      <= '0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            cnt_r           <= cnt_next_s;
            base_r          <= base_next_s;
            unc_r           <= unc_next_s;
            line_r          <= line_next_s;
            mem_req_valid_r <= (state_next_s == tcore_param::REFILL_REQ);
            if (state_next_s == tcore_param::REFILL_REQ) begin
                mem_addr_r <= mem_addr_next_s;
            end
            res_valid_r     <= (state_next_s == tcore_param::REFILL_DONE);
            res_data_r      <= (state_next_s == tcore_param::REFILL_DONE) ? line_next_s : '0;
            busy_r          <= (state_next_s != tcore_param::REFILL_IDLE);
        end
    end

    assign mem_req_valid_o = mem_req_s.valid;
    assign mem_addr_o      = mem_req_s.addr;
    assign busy_o          = busy_r;
    assign lowX_res_o      = '{valid: res_valid_r, data: res_data_r, error: 1'b0};

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: a word-memory responder with
// programmable stalls and stray response pulses, and a line-level reference
// that predicts read addresses, the returned line and the response cycle.
module tb_icache_refill;
    import tcore_param::*;

    localparam int W = BLK_SIZE / 32;

    logic        clk;
    logic        rst;
    ilowX_req_t  lreq;
    ilowX_res_t  lres;
    logic        mreq_valid;
    logic        mreq_ready;
    logic [31:0] maddr;
    logic        mrsp_valid;
    logic [31:0] mrsp_data;
    logic        busy;

    icache_refill dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lowX_req_i      (lreq),
        .lowX_res_o      (lres),
        .mem_req_valid_o (mreq_valid),
        .mem_req_ready_i (mreq_ready),
        .mem_addr_o      (maddr),
        .mem_rsp_valid_i (mrsp_valid),
        .mem_rsp_data_i  (mrsp_data),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: preloaded words, otherwise a fixed function of address.
    logic [31:0] mem_a [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
    endfunction

    // Responder state
    int          req_stall_a [8];
    int          rsp_stall_a [8];
    int          hs_cnt      = 0;
    int          stall_left  = 0;
    int          rsp_wait    = 0;
    bit          rsp_pending = 1'b0;
    bit          in_req      = 1'b0;
    bit          seen_valid  = 1'b0;
    bit          spur_en     = 1'b0;
    logic [31:0] rsp_addr    = 32'h0;
    logic [31:0] held_addr   = 32'h0;
    logic [31:0] addr_q [$];

    // Advance to the next falling edge and run one memory-side cycle.
    task automatic tick();
        bit in_wait;
        @(negedge clk);
        if (rst) begin
            rsp_pending = 1'b0;
            in_req      = 1'b0;
            seen_valid  = 1'b0;
            mreq_ready  = 1'b0;
            mrsp_valid  = 1'b0;
            return;
        end
        if (seen_valid && mreq_ready) begin
            rsp_pending = 1'b1;
            rsp_wait    = rsp_stall_a[hs_cnt % 8];
            hs_cnt++;
            in_req      = 1'b0;
        end
        in_wait    = rsp_pending;
        mrsp_valid = 1'b0;
        mrsp_data  = $urandom;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                mrsp_valid  = 1'b1;
                mrsp_data   = mem_rd(rsp_addr);
                rsp_pending = 1'b0;
            end else begin
                rsp_wait--;
            end
        end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
            mrsp_valid = 1'b1;
        end
        seen_valid = mreq_valid;
        mreq_ready = 1'b0;
        if (mreq_valid) begin
            check_eq("one_outstanding", in_wait, 1'b0);
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = req_stall_a[hs_cnt % 8];
                held_addr  = maddr;
            end else begin
                check_eq("addr_stable", maddr, held_addr);
            end
            if (stall_left == 0) begin
                mreq_ready = 1'b1;
                addr_q.push_back(maddr);
                rsp_addr = maddr;
            end else begin
                stall_left--;
            end
        end else if (in_req) begin
            check_eq("req_held", mreq_valid, 1'b1);
            in_req = 1'b0;
        end
    endtask

    task automatic set_stalls(input int maxs);
        for (int i = 0; i < 8; i++) begin
            req_stall_a[i] = (maxs == 0) ? 0 : int'($urandom_range(0, maxs));
            rsp_stall_a[i] = (maxs == 0) ? 0 : int'($urandom_range(0, maxs));
        end
    endtask

    // One miss from acceptance to response, checked against the line model.
    // Called at a falling edge with the engine idle; returns one cycle after
    // the response, which is the earliest cycle a new miss may be presented.
    task automatic do_miss(input logic [31:0] addr, input bit unc, input bit hold);
        logic [31:0]        base;
        logic [W-1:0][31:0] exp_line;
        int                 nw;
        int                 exp_lat;
        int                 k;
        int                 lane;
        bit                 got;
        base     = unc ? (addr & ~32'd3) : (addr & ~(32'(BLK_SIZE / 8) - 32'd1));
        nw       = unc ? 1 : W;
        exp_lat  = unc ? 3 : 2 * W + 1;
        exp_line = '0;
        for (int i = 0; i < nw; i++) begin
            lane           = unc ? int'((base >> 2) & 32'(W - 1)) : i;
            exp_line[lane] = mem_rd(base + 32'(4 * i));
            exp_lat        = exp_lat + req_stall_a[i] + rsp_stall_a[i];
        end
        check_eq("idle_before", busy, 1'b0);
        check_eq("no_stray_rsp", lres.valid, 1'b0);
        addr_q.delete();
        hs_cnt = 0;
        lreq   = '{valid: 1'b1, ready: 1'b1, addr: addr, uncached: unc};
        got = 1'b0;
        k   = 0;
        while (!got && k < 300) begin
            tick();
            k++;
            if (k == 1) begin
                check_eq("busy_accept", busy, 1'b1);
                if (!hold) begin
                    lreq.valid    = 1'b0;
                    lreq.addr     = $urandom;
                    lreq.uncached = 1'($urandom_range(0, 1));
                end
            end
            if (lres.valid) got = 1'b1;
        end
        check_eq("rsp_seen", got, 1'b1);
        check_eq("latency", k, exp_lat);
        check_eq("line", lres.data, exp_line);
        check_eq("err_zero", lres.error, 1'b0);
        check_eq("nreads", addr_q.size(), nw);
        for (int i = 0; i < nw && i < addr_q.size(); i++) begin
            check_eq("rd_addr", addr_q[i], base + 32'(4 * i));
        end
        tick();
        check_eq("pulse_width", lres.valid, 1'b0);
    endtask

    // Reset while waiting for word 2, then confirm a clean restart.
    task automatic reset_mid();
        int k;
        set_stalls(0);
        addr_q.delete();
        hs_cnt = 0;
        lreq   = '{valid: 1'b1, ready: 1'b1, addr: 32'h0000_5000, uncached: 1'b0};
        tick();
        lreq.valid = 1'b0;
        k = 0;
        while (hs_cnt < 3 && k < 50) begin
            tick();
            k++;
        end
        check_eq("reach_wait2", hs_cnt, 3);
        rst = 1'b1;
        tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req_valid", mreq_valid, 1'b0);
        check_eq("rst_res_valid", lres.valid, 1'b0);
        rst = 1'b0;
        do_miss(32'h0000_4000, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        lreq       = '0;
        mreq_ready = 1'b0;
        mrsp_valid = 1'b0;
        mrsp_data  = 32'h0;
        set_stalls(0);
        repeat (3) tick();
        check_eq("rst_res_valid0", lres.valid, 1'b0);
        check_eq("rst_res_data0", lres.data, '0);
        check_eq("rst_mem_valid0", mreq_valid, 1'b0);
        check_eq("rst_mem_addr0", maddr, 32'h0);
        check_eq("rst_busy0", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Directed cached miss
        mem_a[32'h0000_1230] = 32'h0000_00A0;
        mem_a[32'h0000_1234] = 32'h0000_00A1;
        mem_a[32'h0000_1238] = 32'h0000_00A2;
        mem_a[32'h0000_123C] = 32'h0000_00A3;
        do_miss(32'h0000_1234, 1'b0, 1'b0);

        // Directed uncached miss
        mem_a[32'h0000_2008] = 32'hDEAD_BEEF;
        do_miss(32'h0000_2008, 1'b1, 1'b0);

        // Request backpressure on word 1 with stray response pulses
        set_stalls(0);
        req_stall_a[1] = 3;
        spur_en        = 1'b1;
        do_miss(32'h0000_1234, 1'b0, 1'b0);
        set_stalls(0);
        spur_en = 1'b0;

        reset_mid();

        // Back-to-back with the request held valid through the response
        do_miss(32'h0000_3000, 1'b0, 1'b1);
        do_miss(32'h0000_3104, 1'b1, 1'b1);
        do_miss(32'h0000_3200, 1'b0, 1'b1);
        lreq.valid = 1'b0;

        // Top-of-memory line
        do_miss(32'hFFFF_FFF4, 1'b0, 1'b0);

        // Randomised misses with random stalls
        for (int t = 0; t < 24; t++) begin
            set_stalls(2);
            spur_en = 1'($urandom_range(0, 1));
            do_miss($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        lreq.valid = 1'b0;
        spur_en    = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
